shift_arbiter: RTL and testbench

- Shares one 32-bit combinational shift core between two requesters (REQ0, REQ1) using round-robin arbitration.
- Each requester sends an operand, a shift amount and an op code over a valid/ready handshake.
- The winning request is shifted and captured in a one-entry output register, returned with its requester ID under valid/ready backpressure.
- Sits between the ALU issue logic and the writeback mux.

---
 rtl/shift_arb_pkg.sv | 16 +
 rtl/shift_core.sv | 39 +++
 rtl/shift_arbiter.sv | 132 +++++++++++++
 tb/tb_shift_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// Shared constants for the shift arbiter: op codes, default widths and output state encodings.
package shift_arb_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef logic [1:0] op_t;

  localparam op_t OP_SRL = 2'd0;
  localparam op_t OP_SLL = 2'd1;
  localparam op_t OP_SRA = 2'd2;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter: SRL/SLL/SRA with saturation of out-of-range amounts; op 3 acts as SRL.
module shift_core
  import shift_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic [WIDTH-1:0] x,
  input  logic [31:0]      y,
  input  op_t              op,
  output logic [WIDTH-1:0] z
);

  logic                     out_of_range;
  logic [SHAMT_W-1:0]       shamt;
  logic signed [WIDTH-1:0]  x_s;
  logic [WIDTH-1:0]         srl_z;
  logic [WIDTH-1:0]         sll_z;
  logic signed [WIDTH-1:0]  sra_z;

  // Any amount bit above the in-range field means the whole operand is shifted out.
  assign out_of_range = |y[31:SHAMT_W];
  assign shamt        = y[SHAMT_W-1:0];
  assign x_s          = $signed(x);

  assign srl_z = x >> shamt;
  assign sll_z = x << shamt;
  assign sra_z = x_s >>> shamt;

  always_comb begin
    z = '0;
    unique case (op)
      OP_SLL:  z = out_of_range ? '0 : sll_z;
      OP_SRA:  z = out_of_range ? {WIDTH{x[WIDTH-1]}} : $unsigned(sra_z);
      default: z = out_of_range ? '0 : srl_z;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters, with a one-entry result register.
// Optional grant/stall statistics counters are built when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [31:0]      req0_y,
  input  op_t              req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [31:0]      req1_y,
  input  op_t              req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]      grant0_cnt,
  output logic [15:0]      grant1_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  logic             state_p0;
  logic             ptr_p0;
  logic             alive_p0;
  logic [WIDTH-1:0] rsp_z_p0;
  logic             rsp_id_p0;

  logic             both_vld;
  logic             gnt0;
  logic             gnt1;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_x;
  logic [31:0]      sel_y;
  op_t              sel_op;
  logic [WIDTH-1:0] core_z;

  // alive_p0 is cleared by reset, so no request can be accepted while rstb is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) alive_p0 <= 1'b0;
    else       alive_p0 <= 1'b1;
  end

  assign both_vld   = req0_valid && req1_valid;
  assign gnt0       = req0_valid && (!req1_valid || !ptr_p0);
  assign gnt1       = req1_valid && (!req0_valid ||  ptr_p0);
  assign can_accept = alive_p0 && ((state_p0 == ST_EMPTY) || rsp_ready);

  assign req0_ready = can_accept && gnt0;
  assign req1_ready = can_accept && gnt1;
  assign accept     = req0_ready || req1_ready;

  assign sel_x  = gnt1 ? req1_x  : req0_x;
  assign sel_y  = gnt1 ? req1_y  : req0_y;
  assign sel_op = gnt1 ? req1_op : req0_op;

  shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .x  (sel_x),
    .y  (sel_y),
    .op (sel_op),
    .z  (core_z)
  );

  // Stage p0: result register and output state
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_p0  <= ST_EMPTY;
      ptr_p0    <= 1'b0;
      rsp_z_p0  <= '0;
      rsp_id_p0 <= 1'b0;
    end else begin
      if (accept) begin
        state_p0  <= ST_FULL;
        rsp_z_p0  <= core_z;
        rsp_id_p0 <= gnt1;
      end else if (rsp_ready) begin
        state_p0  <= ST_EMPTY;
      end
      if (accept && both_vld)
        ptr_p0 <= !gnt1;
    end
  end

  assign rsp_valid = (state_p0 == ST_FULL);
  assign rsp_z     = rsp_z_p0;
  assign rsp_id    = rsp_id_p0;

`ifdef SHIFT_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] grant0_cnt_p0;
  logic [15:0] grant1_cnt_p0;
  logic [15:0] stall_cnt_p0;

  // A contention cycle is one where both request and the loser is held back by the grant.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      grant0_cnt_p0 <= '0;
      grant1_cnt_p0 <= '0;
      stall_cnt_p0  <= '0;
    end else begin
      if (req0_ready)
        grant0_cnt_p0 <= sat_inc16(grant0_cnt_p0);
      if (req1_ready)
        grant1_cnt_p0 <= sat_inc16(grant1_cnt_p0);
      if (both_vld && can_accept)
        stall_cnt_p0 <= sat_inc16(stall_cnt_p0);
    end
  end

  assign grant0_cnt = grant0_cnt_p0;
  assign grant1_cnt = grant1_cnt_p0;
  assign stall_cnt  = stall_cnt_p0;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter; statistics checks are included when SHIFT_ARB_STATS_EN is defined.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_x, req0_y;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_x, req1_y;
  logic [1:0]  req1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_id;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk        (clk),
    .rstb       (rstb),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_id     (rsp_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    req0_valid = v; req0_x = x; req0_y = y; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    req1_valid = v; req1_x = x; req1_y = y; req1_op = op;
  endtask

  // One req0 transaction with rsp_ready high: accept next edge, result visible right after it.
  task automatic shot0(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [1:0] op, input logic [31:0] exp);
    set0(1'b1, x, y, op);
    #1;
    chk({tag, "_ready"}, {31'd0, req0_ready}, 32'd1);
    tick();
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_z"}, rsp_z, exp);
    chk({tag, "_id"}, {31'd0, rsp_id}, 32'd0);
  endtask

  initial begin
    logic [31:0] sx;
    rstb = 1'b0; rsp_ready = 1'b0;
    set0(1'b0, '0, '0, 2'd0);
    set1(1'b0, '0, '0, 2'd0);
    #12;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_z", rsp_z, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    rstb = 1'b1;
    tick();
    tick();

    // SRL sweep on requester 0
    rsp_ready = 1'b1;
    sx = 32'h8A1BC97A;
    for (int k = 0; k < 32; k++)
      shot0($sformatf("srl%0d", k), sx, k, 2'd0, sx >> k);
    shot0("srl32", sx, 32'd32, 2'd0, 32'h0);
    shot0("srlmax", sx, 32'hFFFFFFFF, 2'd0, 32'h0);

    // Arithmetic/left boundaries and the reserved op
    shot0("sra31", 32'h80000000, 32'd31, 2'd2, 32'hFFFFFFFF);
    shot0("sra40", 32'h80000000, 32'd40, 2'd2, 32'hFFFFFFFF);
    shot0("sra40pos", 32'h7FFFFFFF, 32'd40, 2'd2, 32'h00000000);
    shot0("sra4", 32'h80000000, 32'd4, 2'd2, 32'hF8000000);
    shot0("sll31", 32'h00000001, 32'd31, 2'd1, 32'h80000000);
    shot0("sll32", 32'h00000001, 32'd32, 2'd1, 32'h0);
    shot0("sll0", 32'h12345678, 32'd0, 2'd1, 32'h12345678);
    shot0("op3", 32'h000000F0, 32'd4, 2'd3, 32'h0000000F);

    // Contention: alternating grants starting with requester 0, no idle cycles
    set0(1'b1, 32'h12345678, 32'd4, 2'd1);
    set1(1'b1, 32'hF0000000, 32'd4, 2'd2);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("cont%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("cont%0d_id", k), {31'd0, rsp_id}, k % 2);
      chk($sformatf("cont%0d_z", k), rsp_z, (k % 2 == 0) ? 32'h23456780 : 32'hFF000000);
    end

    // Backpressure: held result stays put, nobody is ready
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_r0", k), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp%0d_r1", k), {31'd0, req1_ready}, 32'd0);
      tick();
      chk($sformatf("bp%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_z", k), rsp_z, 32'hFF000000);
      chk($sformatf("bp%0d_id", k), {31'd0, rsp_id}, 32'd1);
    end
    rsp_ready = 1'b1;
    set0(1'b0, '0, '0, 2'd0);
    set1(1'b1, 32'h000000F0, 32'd4, 2'd0);
    #1;
    chk("drain_r1", {31'd0, req1_ready}, 32'd1);
    tick();
    chk("drain_valid", {31'd0, rsp_valid}, 32'd1);
    chk("drain_z", rsp_z, 32'h0000000F);
    chk("drain_id", {31'd0, rsp_id}, 32'd1);
    set1(1'b0, '0, '0, 2'd0);
    tick();
    chk("empty_valid", {31'd0, rsp_valid}, 32'd0);
    chk("empty_zhold", rsp_z, 32'h0000000F);
    chk("empty_idhold", {31'd0, rsp_id}, 32'd1);

    // Reset while FULL, asserted between edges
    rsp_ready = 1'b0;
    set0(1'b1, 32'h00000001, 32'd31, 2'd1);
    tick();
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("pre_rst_z", rsp_z, 32'h80000000);
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_z", rsp_z, 32'h0);
    chk("mid_rst_r0", {31'd0, req0_ready}, 32'd0);
    tick();
    chk("in_rst_valid", {31'd0, rsp_valid}, 32'd0);
    set0(1'b0, '0, '0, 2'd0);
    #2;
    rstb = 1'b1;
    tick();
    rsp_ready = 1'b1;
    set1(1'b1, 32'h000000F0, 32'd4, 2'd0);
    #1;
    chk("post_rst_r1", {31'd0, req1_ready}, 32'd1);
    tick();
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post_rst_z", rsp_z, 32'h0000000F);
    chk("post_rst_id", {31'd0, rsp_id}, 32'd1);
    set0(1'b1, 32'h00000003, 32'd1, 2'd1);
    set1(1'b1, 32'h00000003, 32'd1, 2'd0);
    tick();
    chk("ptr_kept_id", {31'd0, rsp_id}, 32'd0);
    chk("ptr_kept_z", rsp_z, 32'h00000006);
    set0(1'b0, '0, '0, 2'd0);
    set1(1'b0, '0, '0, 2'd0);
    tick();

`ifdef SHIFT_ARB_STATS_EN
    rstb = 1'b0;
    #3;
    rstb = 1'b1;
    tick();
    chk("stat_rst_g0", {16'd0, grant0_cnt}, 32'd0);
    set0(1'b1, 32'h1, 32'd1, 2'd1);
    set1(1'b1, 32'h2, 32'd1, 2'd0);
    for (int k = 0; k < 4; k++) tick();
    set1(1'b0, '0, '0, 2'd0);
    #1;
    chk("stat_g0", {16'd0, grant0_cnt}, 32'd2);
    chk("stat_g1", {16'd0, grant1_cnt}, 32'd2);
    chk("stat_stall", {16'd0, stall_cnt}, 32'd4);
    for (int k = 0; k < 65540; k++) @(posedge clk);
    #1;
    chk("stat_g0_sat", {16'd0, grant0_cnt}, 32'h0000FFFF);
    chk("stat_g1_hold", {16'd0, grant1_cnt}, 32'd2);
    set0(1'b0, '0, '0, 2'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
